// File: rtl/key_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_tx_arbiter
//  Purpose  : Round-robin arbiter and frame sequencer for the car-key serial
//             transmitter. Grants one requester at a time and shifts out the
//             fixed key code followed by the granted requester's index on R,
//             then holds the line idle for GAP cycles.
//
//  Ports    : clk    - single clock, rising edge
//             reset  - asynchronous, active-high; clears all state/outputs
//             req    - [NREQ] level request per requester (sampled in IDLE)
//             grant  - [NREQ] one-hot, high for the whole served frame
//             R      - serial key line (frame bits MSB first)
//             busy   - high while a frame or its trailing gap is in progress
//             done   - one-cycle pulse after the last frame bit
//
//  Build option : KEY_TX_PARITY_EN - when defined, an even-parity bit
//                 (XOR of all code and ID bits) is appended after the ID.
//
//  Revision : 1.0 - initial release
// ============================================================================
module key_tx_arbiter #(
    parameter int                NREQ   = 3,
    parameter int                CODE_W = 4,
    parameter logic [CODE_W-1:0] CODE   = 4'b1101,
    parameter int                GAP    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            R,
    output logic            busy,
    output logic            done
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int c_ID_W = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ);
`ifdef KEY_TX_PARITY_EN
    localparam int c_PAR_W = 1;
`else
    localparam int c_PAR_W = 0;
`endif
    localparam int c_FRAME_W = CODE_W + c_ID_W + c_PAR_W;
    localparam int c_CNT_W   = ($clog2(c_FRAME_W) < 1) ? 1 : $clog2(c_FRAME_W);

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_FRAME_W - 1);
    localparam logic [3:0]         c_GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [c_ID_W-1:0]  c_LAST_IDX = c_ID_W'(NREQ - 1);
    localparam logic [c_ID_W:0]    c_NREQ_EXT = (c_ID_W + 1)'(NREQ);
    localparam bit                 c_HAS_GAP  = (GAP > 0);

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_ID_W-1:0]      r_ptr;       // first index searched next time
    logic [c_CNT_W-1:0]     r_cnt;       // index of the frame bit on R
    logic [3:0]             r_gap_cnt;
    logic [c_FRAME_W-1:0]   r_shift;     // remaining frame bits, MSB next
    logic [NREQ-1:0]        r_grant;
    logic                   r_key;
    logic                   r_busy;
    logic                   r_done;

    // ------------------------------------------------------------------
    // Round-robin search: walk indices ptr, ptr+1, ... wrapping at NREQ
    // and take the first one with an active request.
    // ------------------------------------------------------------------
    logic                   w_found;
    logic [c_ID_W-1:0]      w_win_idx;
    logic [c_ID_W-1:0]      w_cand;
    logic [c_ID_W:0]        w_sum;

    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        w_sum     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W + 1)'(i);
            if (w_sum >= c_NREQ_EXT) begin
                w_cand = c_ID_W'(w_sum - c_NREQ_EXT);
            end else begin
                w_cand = w_sum[c_ID_W-1:0];
            end
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    // Pointer moves to the slot just after the winner.
    logic [c_ID_W-1:0] w_next_ptr;
    assign w_next_ptr = (w_win_idx == c_LAST_IDX) ? '0 : (w_win_idx + c_ID_W'(1));

    // One-hot decode of the winning index.
    logic [NREQ-1:0] w_win_onehot;
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign w_win_onehot[gi] = (w_win_idx == c_ID_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame assembly in transmit order: code, index, optional parity.
    // ------------------------------------------------------------------
    logic [c_FRAME_W-1:0] w_frame;
`ifdef KEY_TX_PARITY_EN
    assign w_frame = {CODE, w_win_idx, ^{CODE, w_win_idx}};
`else
    assign w_frame = {CODE, w_win_idx};
`endif

    // ------------------------------------------------------------------
    // Sequencer. Bit 0 goes out on the same edge that issues the grant,
    // so the shift register is loaded with the frame already shifted once.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_grant   <= '0;
            r_key     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_grant <= '0;
                    r_key   <= 1'b0;
                    r_busy  <= 1'b0;
                    if (w_found) begin
                        r_state <= ST_SEND;
                        r_grant <= w_win_onehot;
                        r_key   <= w_frame[c_FRAME_W-1];
                        r_shift <= {w_frame[c_FRAME_W-2:0], 1'b0};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_next_ptr;
                    end
                end

                ST_SEND: begin
                    if (r_cnt == c_LAST_BIT) begin
                        r_grant   <= '0;
                        r_key     <= 1'b0;
                        r_done    <= 1'b1;
                        r_gap_cnt <= '0;
                        if (c_HAS_GAP) begin
                            r_state <= ST_GAP;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_key   <= r_shift[c_FRAME_W-1];
                        r_shift <= {r_shift[c_FRAME_W-2:0], 1'b0};
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    r_key <= 1'b0;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a quiet IDLE.
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_key   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign R     = r_key;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_key_tx_arbiter
//  Purpose  : Self-checking bench for key_tx_arbiter. Two instances (GAP=2 and
//             GAP=0) are compared every cycle against a frame-level model,
//             plus directed scenarios with hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_tx_arbiter;

    localparam int         NREQ   = 3;
    localparam int         CODE_W = 4;
    localparam logic [3:0] CODE   = 4'b1101;
    localparam int         GAP_A  = 2;
    localparam int         GAP_B  = 0;
`ifdef KEY_TX_PARITY_EN
    localparam int         FW     = 7;
`else
    localparam int         FW     = 6;
`endif
    localparam int         T_IDLE = 1000;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req_a = 3'b000;
    logic [2:0] req_b = 3'b000;
    logic [2:0] grant_a, grant_b;
    logic       r_a, r_b, busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_tx_arbiter #(.NREQ(NREQ), .CODE_W(CODE_W), .CODE(CODE), .GAP(GAP_A)) dut_a (
        .clk(clk), .reset(reset), .req(req_a),
        .grant(grant_a), .R(r_a), .busy(busy_a), .done(done_a)
    );

    key_tx_arbiter #(.NREQ(NREQ), .CODE_W(CODE_W), .CODE(CODE), .GAP(GAP_B)) dut_b (
        .clk(clk), .reset(reset), .req(req_b),
        .grant(grant_b), .R(r_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: per DUT, cycles elapsed since the grant edge,
    // the pointer where the next search begins and the served index.
    // ------------------------------------------------------------------
    int m_t   [2];
    int m_ptr [2];
    int m_idx [2];

    function automatic logic frame_bit(input int idx, input int k);
        logic [3:0] c;
        logic [1:0] id;
        c  = CODE;
        id = idx[1:0];
        if (k < 4) return c[3-k];
        if (k < 6) return id[5-k];
        return (^c) ^ (^id);
    endfunction

    function automatic logic [5:0] model_out(input int d);
        int         t, gap;
        logic [2:0] g;
        logic       rr, b, dn;
        t   = m_t[d];
        gap = (d == 0) ? GAP_A : GAP_B;
        g   = (t < FW) ? 3'(1 << m_idx[d]) : 3'b000;
        rr  = (t < FW) ? frame_bit(m_idx[d], t) : 1'b0;
        b   = (t < FW + gap);
        dn  = (t == FW);
        return {g, rr, b, dn};
    endfunction

    logic [2:0] mdl_rq;
    int         mdl_gap, mdl_j;
    bit         mdl_found;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_t[d]   = T_IDLE;
                m_ptr[d] = 0;
                m_idx[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mdl_rq  = (d == 0) ? req_a : req_b;
                mdl_gap = (d == 0) ? GAP_A : GAP_B;
                if (m_t[d] >= FW + mdl_gap && mdl_rq != 3'b000) begin
                    mdl_found = 1'b0;
                    for (int i = 0; i < NREQ; i++) begin
                        mdl_j = (m_ptr[d] + i) % NREQ;
                        if (!mdl_found && mdl_rq[mdl_j]) begin
                            mdl_found = 1'b1;
                            m_idx[d]  = mdl_j;
                        end
                    end
                    m_ptr[d] = (m_idx[d] + 1) % NREQ;
                    m_t[d]   = 0;
                end else if (m_t[d] < T_IDLE) begin
                    m_t[d] = m_t[d] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cyc_dut_a", int'({grant_a, r_a, busy_a, done_a}), int'(model_out(0)));
        chk("cyc_dut_b", int'({grant_b, r_b, busy_b, done_b}), int'(model_out(1)));
    end

    // ------------------------------------------------------------------
    // Stimulus and directed checks
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Waits (bounded) until grant_a becomes non-zero, sampled at negedge.
    task automatic wait_grant_a(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (grant_a != 3'b000) ok = 1'b1;
        end
        if (!ok) chk(name, 0, 1);
    endtask

`ifdef KEY_TX_PARITY_EN
    logic [5:0] exp_a [FW+GAP_A+1] = '{6'b010110, 6'b010110, 6'b010010, 6'b010110,
                                       6'b010010, 6'b010110, 6'b010010, 6'b000011,
                                       6'b000010, 6'b000000};
`else
    logic [5:0] exp_a [FW+GAP_A+1] = '{6'b010110, 6'b010110, 6'b010010, 6'b010110,
                                       6'b010010, 6'b010110, 6'b000011, 6'b000010,
                                       6'b000000};
`endif
    logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] g_val  [4];
    int         g_cyc  [4];
    int         n_g, n_done, n_idle, first_k;
    logic [2:0] prev;

    initial begin
        #1 reset = 1'b1;
        do_reset();

        // Reset state and single frame for requester 1.
        @(negedge clk);
        chk("reset_state", int'({grant_a, r_a, busy_a, done_a}), 0);
        req_a = 3'b010;
        for (int k = 0; k < FW + GAP_A + 1; k++) begin
            @(negedge clk);
            if (k == 0) req_a = 3'b000;
            chk($sformatf("frame1_k%0d", k), int'({grant_a, r_a, busy_a, done_a}), int'(exp_a[k]));
        end

        // All requesters held from reset: round-robin order and period.
        do_reset();
        @(negedge clk);
        req_a = 3'b111;
        prev  = 3'b000;
        n_g   = 0;
        for (int i = 0; i < 4; i++) begin g_val[i] = 3'b000; g_cyc[i] = 0; end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (grant_a != 3'b000 && prev == 3'b000 && n_g < 4) begin
                g_cyc[n_g] = c;
                g_val[n_g] = grant_a;
                n_g++;
            end
            prev = grant_a;
        end
        req_a = 3'b000;
        chk("rr_count", n_g, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), int'(g_val[i]), int'(rr_exp[i]));
        for (int i = 1; i < 4; i++) chk($sformatf("rr_period%0d", i), g_cyc[i] - g_cyc[i-1], FW + GAP_A + 1);

        // Request swapped mid-frame: frame completes, req[2] waits for the gap.
        do_reset();
        @(negedge clk);
        req_a = 3'b010;
        wait_grant_a("midswap_grant_timeout");
        chk("midswap_grant", int'(grant_a), 3'b010);
        first_k = -1;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (k == 2) req_a = 3'b100;
            if (k == FW - 1) chk("midswap_hold", int'(grant_a), 3'b010);
            if (first_k < 0 && grant_a == 3'b100) first_k = k;
        end
        req_a = 3'b000;
        chk("midswap_next_edge", first_k, FW + GAP_A + 1);

        // Asynchronous reset during bit 3.
        do_reset();
        @(negedge clk);
        req_a = 3'b001;
        wait_grant_a("abort_grant_timeout");
        req_a = 3'b000;
        repeat (3) @(negedge clk);
        chk("abort_before", int'({grant_a, r_a, busy_a}), 5'b00111);
        #2 reset = 1'b1;
        #1 chk("abort_outputs", int'({grant_a, r_a, busy_a, done_a}), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        req_a = 3'b110;
        @(negedge clk);
        chk("abort_ptr_reset", int'(grant_a), 3'b010);
        req_a = 3'b000;

        // GAP=0 instance with requester 0 held.
        do_reset();
        @(negedge clk);
        req_b  = 3'b001;
        prev   = 3'b000;
        n_g    = 0;
        n_idle = 0;
        for (int i = 0; i < 4; i++) begin g_val[i] = 3'b000; g_cyc[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (grant_b != 3'b000 && prev == 3'b000 && n_g < 3) begin
                g_cyc[n_g] = c;
                g_val[n_g] = grant_b;
                n_g++;
            end
            if (n_g == 1 && !busy_b) n_idle++;
            prev = grant_b;
        end
        req_b = 3'b000;
        chk("gap0_count", n_g, 3);
        chk("gap0_grant", int'(g_val[1]), 3'b001);
        chk("gap0_period1", g_cyc[1] - g_cyc[0], FW + 1);
        chk("gap0_period2", g_cyc[2] - g_cyc[1], FW + 1);
        chk("gap0_idle_cycles", n_idle, 1);

        // Randomized traffic on both instances, with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) req_a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) req_b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
        end
        req_a = 3'b000;
        req_b = 3'b000;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/key_tx_arbiter.md
# key_tx_arbiter

Round-robin arbiter and frame sequencer for the car-key serial transmitter. Door, trunk and ignition requesters share one serial key line. The block grants one requester at a time and shifts out a fixed key code followed by the requester's ID on `R`. It sits between the requester logic and the single-bit key output, and owns all timing on that line.

## Interface
- `NREQ`, 3: number of requesters; legal range 2..8.
- `CODE_W`, 4: key code width in bits.
- `CODE`, 4'b1101: key code, sent MSB first.
- `GAP`, 2: idle cycles with `R`=0 after each frame; legal range 0..15.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs.
- `req`  in  NREQ: level request per requester.
- `grant`  out  NREQ: one-hot; high for the whole frame of the served requester.
- `R`  out  1: serial key line.
- `busy`  out  1: high in SEND and GAP.
- `done`  out  1: one-cycle pulse after the last frame bit.

## Operation
- `ID_W` = max(1, clog2(NREQ)).
- `FRAME_W` = CODE_W + ID_W, plus 1 when parity is enabled.
- Frame layout, in transmit order:
  - `CODE`, MSB first;
  - granted index on ID_W bits, MSB first;
  - optional parity bit.
- States:
  - IDLE: `R`=0, `grant`=0. If `req`≠0, arbitrate and go to SEND.
  - SEND: bit counter runs 0..FRAME_W-1 and `R` shows the current frame bit. After the last bit, go to GAP if GAP>0, else IDLE.
  - GAP: `R`=0 for GAP cycles, then go to IDLE.
- Round-robin arbitration:
  - Search starts at the index after the last granted one and wraps from NREQ-1 to 0.
  - After reset the pointer is 0, so `req[0]` wins first.
  - The pointer updates only when a grant is issued.
- `req` is sampled only in IDLE.
  - Changes to `req` during SEND or GAP are ignored.
  - A request withdrawn mid-frame does not abort the frame.
- A requester holding `req` after `done` is served again, in round-robin order.
- Illegal state encodings go to IDLE with all outputs 0.
- All outputs are registered. After reset, `grant`=0, `R`=0, `busy`=0, `done`=0, state=IDLE, pointer=0.
- Reset asserted mid-frame: outputs drop to 0 asynchronously, the frame is discarded, and no `done` is issued.

## Timing
- Edge numbering: `req` is seen in IDLE at edge N.
- At edge N: `grant` is set, `busy`=1, and `R` shows frame bit 0.
- Frame bit k is visible after edge N+k.
- At edge N+FRAME_W:
  - `grant`→0 and `done`=1 for exactly one cycle;
  - `R`=0;
  - state becomes GAP, or IDLE when GAP=0.
- `busy` falls at edge N+FRAME_W+GAP.
- Earliest next grant is edge N+FRAME_W+GAP+1, so the minimum frame period is FRAME_W+GAP+1 cycles.
- `done` and a new `grant` never assert in the same cycle.

## Configuration
- `KEY_TX_PARITY_EN` defined:
  - an even-parity bit (XOR of all code and ID bits) is appended after the ID;
  - FRAME_W grows by 1 and all timing above shifts accordingly.
- `KEY_TX_PARITY_EN` undefined: no parity bit is sent and the frame is CODE_W+ID_W bits.

## Test plan
- Reset, then `req`=3'b010 held one cycle, GAP=2, parity off:
  - `grant`=010 on the next edge;
  - `R` = 1,1,0,1,0,1 on consecutive cycles;
  - `done` pulses 6 cycles after the grant edge;
  - `busy` stays high 8 cycles total.
- `req`=3'b111 held from reset:
  - grants are issued in the order 001, 010, 100, 001;
  - successive grant edges are 9 cycles apart (6+2+1).
- Parity on, `req`=3'b001:
  - `R` = 1,1,0,1,0,0,1 (7 bits, parity 1);
  - `done` pulses 7 cycles after the grant edge.
- Grant to `req[1]`, then `req[1]` dropped and `req[2]` raised at bit 2:
  - the frame for requester 1 completes unchanged;
  - `req[2]` is granted only after the GAP.
- `reset` pulsed during bit 3:
  - `R`, `grant` and `busy` are 0 immediately and no `done` pulse appears;
  - a subsequent `req`=3'b110 grants 010 (pointer back to 0).
- GAP=0 with `req`=3'b001 held:
  - consecutive frames to requester 0 start 7 cycles apart;
  - `R` is 0 for exactly one cycle between frames.
